// File: rtl/qspi_pkg.sv
// Shared QSPI TX definitions: lane-mode encodings, controller states, FIFO width
// and small per-mode helpers used by the shifter.
package qspi_pkg;

    localparam int FIFO_DW = 32;

    typedef enum logic [1:0] {
        LANE_X1   = 2'd0,
        LANE_X2   = 2'd1,
        LANE_X4   = 2'd2,
        LANE_RSVD = 2'd3
    } lane_mode_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        WAIT_DATA = 3'd2,
        SHIFT     = 3'd3,
        DONE      = 3'd4
    } state_e;

    // Bits moved per shift tick.
    function automatic logic [2:0] unit_bits(lane_mode_e m);
        case (m)
            LANE_X2: return 3'd2;
            LANE_X4: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    // Index of the last unit within one byte.
    function automatic logic [2:0] last_unit(lane_mode_e m);
        case (m)
            LANE_X2: return 3'd3;
            LANE_X4: return 3'd1;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [3:0] lane_oe(lane_mode_e m);
        case (m)
            LANE_X2: return 4'b0011;
            LANE_X4: return 4'b1111;
            default: return 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/qspi_tx_shifter_if.sv
// TX FIFO read-side bundle between the shifter (master) and the FIFO (slave).
interface qspi_tx_shifter_if;
    import qspi_pkg::*;

    logic               fifo_rd_en;
    logic [FIFO_DW-1:0] fifo_rd_data;
    logic               fifo_empty;

    modport master (output fifo_rd_en, input fifo_rd_data, input fifo_empty);
    modport slave  (input fifo_rd_en, output fifo_rd_data, output fifo_empty);

endinterface

// File: rtl/qspi_tx_shifter.sv
// QSPI transmit shifter: pops 32-bit words from the TX FIFO and shifts bytes out
// LSB-byte first, MSB-first per byte, on x1/x2/x4 lanes. Option: QSPI_TX_UNDERRUN_ABORT_EN.
module qspi_tx_shifter
    import qspi_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   byte_count_i,
    input  logic [1:0]         lane_mode_i,
    input  logic               shift_tick_i,
    output logic               fifo_rd_en_o,
    input  logic [FIFO_DW-1:0] fifo_rd_data_i,
    input  logic               fifo_empty_i,
    output logic [3:0]         io_o,
    output logic [3:0]         io_oe_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               underrun_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_dec;
    lane_mode_e         mode_q, mode_d, mode_in;
    logic [FIFO_DW-1:0] sreg_q, sreg_d;
    logic [1:0]         byte_q, byte_d;
    logic [2:0]         unit_q, unit_d;
    logic               started_q, started_d;
    logic               byte_end;

    assign mode_in  = (lane_mode_i == LANE_RSVD) ? LANE_X1 : lane_mode_e'(lane_mode_i);
    assign byte_end = (unit_q == last_unit(mode_q));
    assign cnt_dec  = cnt_q - 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_i) state_d = (byte_count_i != '0) ? FETCH : DONE;
            FETCH: begin
                if (!fifo_empty_i) state_d = WAIT_DATA;
`ifdef QSPI_TX_UNDERRUN_ABORT_EN
                else               state_d = DONE;
`endif
            end
            WAIT_DATA: state_d = SHIFT;
            SHIFT: begin
                if (shift_tick_i && byte_end) begin
                    if (cnt_dec == '0)       state_d = DONE;
                    else if (byte_q == 2'd3) state_d = FETCH;
                end
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_en_o = 1'b0;
        io_o         = '0;
        io_oe_o      = '0;
        busy_o       = (state_q != IDLE);
        done_o       = 1'b0;
        case (state_q)
            FETCH: begin
                fifo_rd_en_o = !fifo_empty_i;
                if (started_q) io_oe_o = lane_oe(mode_q);
            end
            WAIT_DATA: if (started_q) io_oe_o = lane_oe(mode_q);
            SHIFT: begin
                io_oe_o = lane_oe(mode_q);
                case (mode_q)
                    LANE_X2: io_o = {2'b00, sreg_q[7:6]};
                    LANE_X4: io_o = sreg_q[7:4];
                    default: io_o = {3'b000, sreg_q[7]};
                endcase
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    // The current byte always sits in sreg_q[7:0]; finished bytes are dropped
    // by a right shift so the next byte lands in place.
    always_comb begin
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        sreg_d    = sreg_q;
        byte_d    = byte_q;
        unit_d    = unit_q;
        started_d = started_q;
        case (state_q)
            IDLE: begin
                started_d = 1'b0;
                if (start_i) begin
                    cnt_d  = byte_count_i;
                    mode_d = mode_in;
                end
            end
            FETCH: begin
                byte_d = '0;
                unit_d = '0;
            end
            WAIT_DATA: sreg_d = fifo_rd_data_i;
            SHIFT: begin
                started_d = 1'b1;
                if (shift_tick_i) begin
                    if (byte_end) begin
                        cnt_d  = cnt_dec;
                        unit_d = '0;
                        byte_d = byte_q + 2'd1;
                        sreg_d = {8'h00, sreg_q[FIFO_DW-1:8]};
                    end else begin
                        unit_d      = unit_q + 3'd1;
                        sreg_d[7:0] = sreg_q[7:0] << unit_bits(mode_q);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            mode_q    <= LANE_X1;
            sreg_q    <= '0;
            byte_q    <= '0;
            unit_q    <= '0;
            started_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            sreg_q    <= sreg_d;
            byte_q    <= byte_d;
            unit_q    <= unit_d;
            started_q <= started_d;
        end
    end

`ifdef QSPI_TX_UNDERRUN_ABORT_EN
    logic under_q, under_d;

    always_comb begin
        under_d = under_q;
        if (state_q == IDLE && start_i)          under_d = 1'b0;
        else if (state_q == FETCH && fifo_empty_i) under_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) under_q <= 1'b0;
        else         under_q <= under_d;
    end

    assign underrun_o = under_q;
`else
    assign underrun_o = 1'b0;
`endif

endmodule
